// File: rtl/fiq_ctrl_pkg.sv
// fiq_ctrl_pkg: shared types and constants for the FIQ stack controller.
//   state_t : controller FSM states (IDLE -> PUSH|POP -> DONE -> IDLE)
//   op_t    : accepted operation encoding (OP_FIQ, OP_RFI, OP_CL, OP_RL)
//   FB_*    : fb_inc / fb_dec step encodings; WE_* : bank write-enable patterns
package fiq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_FIQ = 2'd0,
    OP_RFI = 2'd1,
    OP_CL  = 2'd2,
    OP_RL  = 2'd3
  } op_t;

  localparam logic [1:0] FB_NONE = 2'b00;
  localparam logic [1:0] FB_ONE  = 2'b01;
  localparam logic [1:0] FB_TWO  = 2'b10;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LINK = 2'b10;
  localparam logic [1:0] WE_BOTH = 2'b11;

  localparam int unsigned NEST_W   = 4;
  localparam logic [3:0]  NEST_MAX = 4'd15;

  // Map a one-hot grant (bit0 fiq, bit1 rfi, bit2 cl, bit3 rl) to an op code.
  function automatic op_t grant_to_op(input logic [3:0] grant);
    op_t op;
    op = OP_FIQ;
    if (grant[1]) op = OP_RFI;
    if (grant[2]) op = OP_CL;
    if (grant[3]) op = OP_RL;
    return op;
  endfunction

endpackage

// File: rtl/fiq_req_arb.sv
// fiq_req_arb: fixed-priority request selector, fiq > rfi > cl > rl.
//   req     [3:0] in  : bit0 fiq, bit1 rfi, bit2 cl, bit3 rl
//   grant_c [3:0] out : one-hot grant (combinational), zero when no request
module fiq_req_arb (
  input  logic [3:0] req,
  output logic [3:0] grant_c
);

  // Lower index wins; losing requests are simply not granted.
  always_comb begin
    grant_c = 4'b0000;
    if (req[0])      grant_c = 4'b0001;
    else if (req[1]) grant_c = 4'b0010;
    else if (req[2]) grant_c = 4'b0100;
    else if (req[3]) grant_c = 4'b1000;
  end

endmodule

// File: rtl/fiq_stack_ctrl.sv
// fiq_stack_ctrl: sequences pushes/pops of link and SPSR words into an external
// FIQ register bank, tracking stack occupancy (sp) and FIQ nesting (fiq_nest).
//   clk, reset (async, active-high)
//   fiq_req / rfi_req / cl_req / rl_req : operation requests (sampled in IDLE)
//   link_in, spsr_in   : push operands        link_out, spsr_out : pop results
//   busy, done, err    : status
//   FIQ_W_En, fb_inc, fb_dec, FIQ_W_Addr, FIQ_R_Addr, FIQ_S_Addr,
//   Link_fiq_In, SPSR_fiq_In : bank controls   FIQ_R, FIQ_S : bank read data
//   sp (occupied words), fiq_nest (active FIQ depth)
// Optional: define FIQ_STACK_CTRL_GUARD_EN to reject overflow/underflow/
// unbalanced-rfi operations and raise a sticky err.
module fiq_stack_ctrl
  import fiq_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fiq_req,
  input  logic          rfi_req,
  input  logic          cl_req,
  input  logic          rl_req,
  input  logic [31:0]   link_in,
  input  logic [31:0]   spsr_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   link_out,
  output logic [31:0]   spsr_out,
  output logic [1:0]    FIQ_W_En,
  output logic [1:0]    fb_inc,
  output logic [1:0]    fb_dec,
  output logic [AW-1:0] FIQ_W_Addr,
  output logic [AW-1:0] FIQ_R_Addr,
  output logic [AW-1:0] FIQ_S_Addr,
  output logic [31:0]   Link_fiq_In,
  output logic [31:0]   SPSR_fiq_In,
  input  logic [31:0]   FIQ_R,
  input  logic [31:0]   FIQ_S,
  output logic [AW:0]   sp,
  output logic [3:0]    fiq_nest
);

  state_t     state;
  op_t        op_q;
  logic       rej_q;
  logic [3:0] grant_c;
  op_t        req_op_c;
  logic       reject_c;

  fiq_req_arb u_arb (
    .req     ({rl_req, cl_req, rfi_req, fiq_req}),
    .grant_c (grant_c)
  );

  assign req_op_c = grant_to_op(grant_c);

  // sp moves over 0..DEPTH, i.e. wraps modulo DEPTH+1.
  function automatic logic [AW:0] sp_step(input logic [AW:0] s, input logic up,
                                          input int unsigned k);
    logic [AW+1:0] s_ext;
    logic [AW+1:0] v;
    s_ext = {1'b0, s};
    if (up) begin
      v = s_ext + (AW+2)'(k);
      if (v > (AW+2)'(DEPTH)) v = v - (AW+2)'(DEPTH + 1);
    end else if (s_ext >= (AW+2)'(k)) begin
      v = s_ext - (AW+2)'(k);
    end else begin
      v = s_ext + (AW+2)'(DEPTH + 1) - (AW+2)'(k);
    end
    return v[AW:0];
  endfunction

`ifdef FIQ_STACK_CTRL_GUARD_EN
  logic [AW:0] free_c;
  assign free_c = (AW+1)'(DEPTH) - sp;

  // Reject when the bank cannot hold / does not contain the words moved.
  always_comb begin
    reject_c = 1'b0;
    case (req_op_c)
      OP_FIQ:  reject_c = free_c < (AW+1)'(2);
      OP_CL:   reject_c = free_c == '0;
      OP_RFI:  reject_c = (sp < (AW+1)'(2)) || (fiq_nest == '0);
      OP_RL:   reject_c = sp == '0;
      default: reject_c = 1'b0;
    endcase
  end

  // Sticky error, raised in the cycle the rejected operation would execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if ((state == ST_PUSH || state == ST_POP) && rej_q) err <= 1'b1;
  end
`else
  assign reject_c = 1'b0;
  assign err      = 1'b0;
`endif

  // Controller FSM; bank controls are registered on acceptance so they are
  // valid throughout the PUSH/POP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= OP_FIQ;
      rej_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      link_out    <= '0;
      spsr_out    <= '0;
      FIQ_W_En    <= WE_NONE;
      fb_inc      <= FB_NONE;
      fb_dec      <= FB_NONE;
      FIQ_W_Addr  <= '0;
      FIQ_R_Addr  <= '0;
      FIQ_S_Addr  <= '0;
      Link_fiq_In <= '0;
      SPSR_fiq_In <= '0;
      sp          <= '0;
      fiq_nest    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant_c) begin
            op_q        <= req_op_c;
            rej_q       <= reject_c;
            busy        <= 1'b1;
            Link_fiq_In <= link_in;
            SPSR_fiq_In <= spsr_in;
            FIQ_W_Addr  <= sp[AW-1:0];
            case (req_op_c)
              OP_FIQ: begin
                state <= ST_PUSH;
                if (!reject_c) begin
                  FIQ_W_En <= WE_BOTH;
                  fb_inc   <= FB_TWO;
                end
              end
              OP_CL: begin
                state <= ST_PUSH;
                if (!reject_c) begin
                  FIQ_W_En <= WE_LINK;
                  fb_inc   <= FB_ONE;
                end
              end
              OP_RFI: begin
                state      <= ST_POP;
                FIQ_R_Addr <= sp[AW-1:0] - AW'(2);
                FIQ_S_Addr <= sp[AW-1:0] - AW'(1);
                if (!reject_c) fb_dec <= FB_TWO;
              end
              default: begin
                state      <= ST_POP;
                FIQ_R_Addr <= sp[AW-1:0] - AW'(1);
                if (!reject_c) fb_dec <= FB_ONE;
              end
            endcase
          end
        end
        ST_PUSH: begin
          FIQ_W_En <= WE_NONE;
          fb_inc   <= FB_NONE;
          done     <= 1'b1;
          state    <= ST_DONE;
          if (!rej_q) begin
            if (op_q == OP_FIQ) begin
              sp <= sp_step(sp, 1'b1, 32'd2);
              if (fiq_nest != NEST_MAX) fiq_nest <= fiq_nest + 4'd1;
            end else begin
              sp <= sp_step(sp, 1'b1, 32'd1);
            end
          end
        end
        ST_POP: begin
          fb_dec <= FB_NONE;
          done   <= 1'b1;
          state  <= ST_DONE;
          if (!rej_q) begin
            link_out <= FIQ_R;
            if (op_q == OP_RFI) begin
              spsr_out <= FIQ_S;
              sp       <= sp_step(sp, 1'b0, 32'd2);
              if (fiq_nest != '0) fiq_nest <= fiq_nest - 4'd1;
            end else begin
              sp <= sp_step(sp, 1'b0, 32'd1);
            end
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fiq_stack_ctrl.sv
// tb_fiq_stack_ctrl: self-checking bench for fiq_stack_ctrl with a behavioural
// register bank, a table of operations with expected results, a pop-result
// scoreboard, and hand-written arbitration / wrap / guard / reset sequences.
module tb_fiq_stack_ctrl;
  import fiq_ctrl_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          fiq_req, rfi_req, cl_req, rl_req;
  logic [31:0]   link_in, spsr_in;
  logic          busy, done, err;
  logic [31:0]   link_out, spsr_out;
  logic [1:0]    FIQ_W_En, fb_inc, fb_dec;
  logic [AW-1:0] FIQ_W_Addr, FIQ_R_Addr, FIQ_S_Addr;
  logic [31:0]   Link_fiq_In, SPSR_fiq_In;
  logic [31:0]   FIQ_R, FIQ_S;
  logic [AW:0]   sp;
  logic [3:0]    fiq_nest;

  int checks = 0;
  int errors = 0;

  logic [31:0] bank [DEPTH];
  logic [63:0] sb_q [$];

  fiq_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .fiq_req(fiq_req), .rfi_req(rfi_req), .cl_req(cl_req), .rl_req(rl_req),
    .link_in(link_in), .spsr_in(spsr_in),
    .busy(busy), .done(done), .err(err),
    .link_out(link_out), .spsr_out(spsr_out),
    .FIQ_W_En(FIQ_W_En), .fb_inc(fb_inc), .fb_dec(fb_dec),
    .FIQ_W_Addr(FIQ_W_Addr), .FIQ_R_Addr(FIQ_R_Addr), .FIQ_S_Addr(FIQ_S_Addr),
    .Link_fiq_In(Link_fiq_In), .SPSR_fiq_In(SPSR_fiq_In),
    .FIQ_R(FIQ_R), .FIQ_S(FIQ_S),
    .sp(sp), .fiq_nest(fiq_nest)
  );

  always #5 clk = ~clk;

  // Behavioural bank: link at W_Addr, SPSR at W_Addr+1, combinational reads.
  initial for (int i = 0; i < DEPTH; i++) bank[i] = '0;
  always @(posedge clk) begin
    if (FIQ_W_En[1]) bank[FIQ_W_Addr] <= Link_fiq_In;
    if (FIQ_W_En[0]) bank[FIQ_W_Addr + AW'(1)] <= SPSR_fiq_In;
  end
  assign FIQ_R = bank[FIQ_R_Addr];
  assign FIQ_S = bank[FIQ_S_Addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare pop results in the cycle done is seen.
  always @(negedge clk) begin
    if (done === 1'b1 && sb_q.size() > 0) begin
      logic [63:0] e;
      e = sb_q.pop_front();
      check("sb_link_out", link_out, e[63:32]);
      check("sb_spsr_out", spsr_out, e[31:0]);
    end
  end

  typedef struct {
    op_t         op;
    logic [31:0] link, spsr;
    logic [1:0]  we, inc, dec;
    logic [AW-1:0] waddr, raddr, saddr;
    logic [AW:0] sp;
    logic [3:0]  nest;
    logic        err;
    bit          out_chk;
    logic [31:0] elink, espsr;
  } vec_t;

  function automatic vec_t mk(op_t op, logic [31:0] link, logic [31:0] spsr,
                              logic [1:0] we, logic [1:0] inc, logic [1:0] dec,
                              int waddr, int raddr, int saddr, int spv, int nest,
                              logic e, bit oc, logic [31:0] elink, logic [31:0] espsr);
    vec_t v;
    v.op = op; v.link = link; v.spsr = spsr;
    v.we = we; v.inc = inc; v.dec = dec;
    v.waddr = AW'(waddr); v.raddr = AW'(raddr); v.saddr = AW'(saddr);
    v.sp = (AW+1)'(spv); v.nest = 4'(nest); v.err = e;
    v.out_chk = oc; v.elink = elink; v.espsr = espsr;
    return v;
  endfunction

  // One request, then checks at T+1 (controls), T+2 (done/state), T+3 (idle).
  task automatic do_op(input vec_t v, input string tag);
    bit is_pop;
    is_pop = (v.op == OP_RFI) || (v.op == OP_RL);
    @(negedge clk);
    fiq_req = (v.op == OP_FIQ); rfi_req = (v.op == OP_RFI);
    cl_req  = (v.op == OP_CL);  rl_req  = (v.op == OP_RL);
    link_in = v.link; spsr_in = v.spsr;
    if (v.out_chk && is_pop) sb_q.push_back({v.elink, v.espsr});
    @(negedge clk);
    {fiq_req, rfi_req, cl_req, rl_req} = 4'b0000;
    check({tag, " w_en"},   32'(FIQ_W_En), 32'(v.we));
    check({tag, " fb_inc"}, 32'(fb_inc),   32'(v.inc));
    check({tag, " fb_dec"}, 32'(fb_dec),   32'(v.dec));
    if (v.we != 2'b00) check({tag, " w_addr"}, 32'(FIQ_W_Addr), 32'(v.waddr));
    if (v.dec != 2'b00) check({tag, " r_addr"}, 32'(FIQ_R_Addr), 32'(v.raddr));
    if (v.dec != 2'b00 && v.op == OP_RFI) check({tag, " s_addr"}, 32'(FIQ_S_Addr), 32'(v.saddr));
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " sp"},   32'(sp),   32'(v.sp));
    check({tag, " nest"}, 32'(fiq_nest), 32'(v.nest));
    check({tag, " err"},  32'(err),  32'(v.err));
    if (v.out_chk && !is_pop) begin
      check({tag, " hold_link"}, link_out, v.elink);
      check({tag, " hold_spsr"}, spsr_out, v.espsr);
    end
    @(negedge clk);
    check({tag, " done_1cyc"}, 32'(done), 32'd0);
    check({tag, " busy_off"},  32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, " rst_sp"},   32'(sp), 32'd0);
    check({tag, " rst_busy"}, 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check({tag, " rst_nest"}, 32'(fiq_nest), 32'd0);
    check({tag, " rst_err"},  32'(err), 32'd0);
    check({tag, " rst_link"}, link_out, 32'd0);
  endtask

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    {fiq_req, rfi_req, cl_req, rl_req} = 4'b0000;
    link_in = '0; spsr_in = '0;

    //            op      link    spsr   we     inc    dec   wa ra sa sp ne er oc elink   espsr
    tbl[0] = mk(OP_FIQ, 32'h100, 32'h1F, 2'b11, 2'b10, 2'b00, 0, 0, 0, 2, 1, 0, 1, 32'h0,   32'h0);
    tbl[1] = mk(OP_CL,  32'h200, 32'h0,  2'b10, 2'b01, 2'b00, 2, 0, 0, 3, 1, 0, 1, 32'h0,   32'h0);
    tbl[2] = mk(OP_RL,  32'h0,   32'h0,  2'b00, 2'b00, 2'b01, 0, 2, 0, 2, 1, 0, 1, 32'h200, 32'h0);
    tbl[3] = mk(OP_RFI, 32'h0,   32'h0,  2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, 1, 32'h100, 32'h1F);
    tbl[4] = mk(OP_FIQ, 32'h111, 32'h2A, 2'b11, 2'b10, 2'b00, 0, 0, 0, 2, 1, 0, 1, 32'h100, 32'h1F);
    tbl[5] = mk(OP_FIQ, 32'h222, 32'h3B, 2'b11, 2'b10, 2'b00, 2, 0, 0, 4, 2, 0, 1, 32'h100, 32'h1F);
    tbl[6] = mk(OP_CL,  32'h333, 32'h0,  2'b10, 2'b01, 2'b00, 4, 0, 0, 5, 2, 0, 1, 32'h100, 32'h1F);
    tbl[7] = mk(OP_RL,  32'h0,   32'h0,  2'b00, 2'b00, 2'b01, 0, 4, 0, 4, 2, 0, 1, 32'h333, 32'h1F);
    tbl[8] = mk(OP_RFI, 32'h0,   32'h0,  2'b00, 2'b00, 2'b10, 0, 2, 3, 2, 1, 0, 1, 32'h222, 32'h3B);
    tbl[9] = mk(OP_RFI, 32'h0,   32'h0,  2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, 1, 32'h111, 32'h2A);

    repeat (2) @(negedge clk);
    check("reset w_en", 32'(FIQ_W_En), 32'd0);
    check("reset done", 32'(done), 32'd0);
    do_reset("init");

    for (int i = 0; i < 10; i++) do_op(tbl[i], $sformatf("row%0d", i));

    // Simultaneous fiq+cl+rl held through the busy window: only fiq executes.
    @(negedge clk);
    fiq_req = 1'b1; cl_req = 1'b1; rl_req = 1'b1;
    link_in = 32'h444; spsr_in = 32'h4C;
    @(negedge clk);
    check("arb w_en",   32'(FIQ_W_En), 32'd3);
    check("arb w_addr", 32'(FIQ_W_Addr), 32'd0);
    check("arb fb_dec", 32'(fb_dec), 32'd0);
    @(negedge clk);
    check("arb done", 32'(done), 32'd1);
    @(negedge clk);
    {fiq_req, rfi_req, cl_req, rl_req} = 4'b0000;
    repeat (3) @(negedge clk);
    check("arb sp",   32'(sp), 32'd2);
    check("arb nest", 32'(fiq_nest), 32'd1);
    check("arb busy", 32'(busy), 32'd0);
    do_op(mk(OP_RFI, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, 1, 32'h444, 32'h4C), "arb_rfi");

    // Pop from an empty stack.
`ifdef FIQ_STACK_CTRL_GUARD_EN
    do_op(mk(OP_RL, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0), "guard_rl_empty");
`else
    do_op(mk(OP_RL, 0, 0, 2'b00, 2'b00, 2'b01, 0, 31, 0, 32, 0, 0, 0, 0, 0), "wrap_rl_empty");
    do_op(mk(OP_CL, 32'h777, 0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), "wrap_cl_full");
`endif
    do_reset("mid");

    // Fill the bank with 16 FIQ frames; nest saturates at 15.
    for (int i = 0; i < 16; i++) begin
      v = mk(OP_FIQ, 32'h1000 + 32'(i), 32'(i), 2'b11, 2'b10, 2'b00, 2 * i, 0, 0,
             2 * i + 2, (i + 1 > 15) ? 15 : i + 1, 0, 0, 0, 0);
      do_op(v, $sformatf("fill%0d", i));
    end
`ifdef FIQ_STACK_CTRL_GUARD_EN
    do_op(mk(OP_CL, 32'h888, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 32, 15, 1, 0, 0, 0), "guard_cl_full");
`else
    do_op(mk(OP_CL, 32'h888, 0, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 15, 0, 0, 0, 0), "wrap_cl_32");
`endif
    do_reset("pre_abort");

    // Reset in the middle of a PUSH aborts it.
    @(negedge clk);
    fiq_req = 1'b1; link_in = 32'hDEAD; spsr_in = 32'hBEEF;
    @(posedge clk);
    #1 fiq_req = 1'b0;
    check("abort pre w_en", 32'(FIQ_W_En), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("abort w_en",   32'(FIQ_W_En), 32'd0);
    check("abort fb_inc", 32'(fb_inc), 32'd0);
    check("abort sp",     32'(sp), 32'd0);
    check("abort busy",   32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(mk(OP_FIQ, 32'h55, 32'h66, 2'b11, 2'b10, 2'b00, 0, 0, 0, 2, 1, 0, 0, 0, 0), "post_abort_fiq");
    do_op(mk(OP_RFI, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, 1, 32'h55, 32'h66), "post_abort_rfi");

    repeat (3) @(negedge clk);
    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
